caravel_uart_wb_master: RTL and testbench
=========================================

// Module: caravel_uart_wb_master
// PURPOSE
//  UART-to-Wishbone host bridge in the user project area. An external host sends
//  ASCII hex commands over UART (mprj_io[0] rx, mprj_io[1] tx). The bridge runs
//  32-bit Wishbone reads and writes and returns ASCII responses.
//  It lets a host access user registers (e.g. 0x3000_0000, 0x3002_0000) without the management core.
// PARAMETERS
//  BAUD_DIV    15     bit time = 16*(BAUD_DIV+1) clocks (8N2 frame)
//  WB_TIMEOUT  1023   clocks to wait for ack/err before aborting the bus cycle
// PORTS
//  wb_clk_i    in   1   single clock for all logic
//  wb_rst_i    in   1   synchronous reset, active-high
//  uart_rxd    in   1   serial in, idle high
//  uart_txd    out  1   serial out, idle high
//  wbm_cyc_o   out  1   Wishbone cycle
//  wbm_stb_o   out  1   Wishbone strobe
//  wbm_we_o    out  1   1 = write
//  wbm_adr_o   out  32  byte address
//  wbm_dat_o   out  32  write data
//  wbm_sel_o   out  4   byte enables, always 4'hF during a cycle
//  wbm_dat_i   in   32  read data
//  wbm_ack_i   in   1   cycle complete
//  wbm_err_i   in   1   cycle error
// BEHAVIOUR
//  Reset values: uart_txd=1; cyc/stb/we=0; adr/dat=0; sel=0. Reset mid-operation
//   aborts immediately: the bus cycle drops, partial input is discarded and TX goes idle.
//  UART RX: 16x oversampling. Start bit is valid if still low at mid-bit (sample 8).
//   Then 8 data bits, LSB first, sampled at mid-bit. Stop bit is sampled once.
//   If the stop bit is low (framing error), the byte is dropped and the line parser is unchanged.
//  UART TX: start, 8 data bits LSB first, 2 stop bits. A one-byte holding buffer feeds it.
//   The response generator stalls while the buffer is full.
//  After reset release, TX sends the banner "RDY\n" (0x52,0x44,0x59,0x0A).
//  Line parser: CR (0x0D) is ignored. LF (0x0A) ends a command.
//   Tokens are separated by one or more spaces. Hex digits accept 0-9, a-f and A-F.
//   Each hex field takes 1-8 digits, shifted in left. If more than 8 digits arrive, the last 8 are kept.
//   Write command: "wm <addr> <data>\n" -> Wishbone write -> reply "OK\n".
//   Read command: "rm <addr>\n" -> Wishbone read -> reply 8 uppercase hex digits MSB first, then "\n".
//   Any other line is an error: unknown keyword, missing field, non-hex digit, or line longer than 32 chars.
//    The error reply is "ERR\n". An empty line produces no reply.
//   Bytes received while a command is executing or replying are dropped.
//  Wishbone master (classic): cyc, stb and sel=F assert one cycle after the command parses.
//   adr, dat and we stay stable until completion.
//   On ack: cyc/stb drop in the next cycle and read data is latched from wbm_dat_i.
//   On err, or when WB_TIMEOUT clocks pass without ack: the cycle drops and the reply is "TO\n".
//   If ack and err arrive together, ack wins.
//  FSM states: BANNER -> IDLE(parse) -> BUS -> RESP -> IDLE.
//   BUS is entered only on a valid command. RESP returns to IDLE after the last reply byte is queued.
// TESTING
//  1 Reset, release -> "RDY\n" on uart_txd at 8N2, bit time 256 clocks.
//  2 "wm 30020000 11223344\n" -> one write, adr=30020000, dat=11223344, sel=F; reply "OK\n".
//  3 "rm 30000000\n", slave returns 44332211 -> reply "44332211\n". Repeat with
//    lowercase "rm 30000004", slave returns DDCCBBAA -> reply "DDCCBBAA\n".
//  4 "xx 1\n" and "wm 12\n" -> "ERR\n" each, no bus cycle.
//  5 "rm 0\n" with a slave that never acks -> cyc low after WB_TIMEOUT clocks; reply "TO\n".
//  6 RX byte with stop bit 0 -> dropped. Reset asserted while BUS is active -> cyc=0 in the next
//    cycle, then "RDY\n" is sent again after release.

Source files
------------

// File: rtl/caravel_uart_wb_master.sv
// UART-to-Wishbone host bridge: ASCII "wm <addr> <data>" / "rm <addr>" commands
// arrive over an 8N2 UART, run as classic Wishbone cycles, and are answered in ASCII.
module caravel_uart_wb_master #(
   parameter int unsigned BAUD_DIV   = 15,
   parameter int unsigned WB_TIMEOUT = 1023
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        uart_rxd,
   output logic        uart_txd,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);
   localparam int unsigned BIT_CLKS  = 16 * (BAUD_DIV + 1);
   localparam int unsigned HALF_CLKS = 8 * (BAUD_DIV + 1);
   localparam int unsigned CNT_W     = $clog2(BIT_CLKS);
   localparam int unsigned TO_W      = $clog2(WB_TIMEOUT + 1);
   localparam logic [7:0]  CH_LF     = 8'h0A;
   localparam logic [7:0]  CH_CR     = 8'h0D;
   localparam logic [7:0]  CH_SP     = 8'h20;

   typedef enum logic [1:0] {S_BANNER, S_IDLE, S_BUS, S_RESP} state_t;
   typedef enum logic [2:0] {R_BANNER, R_OK, R_ERR, R_TO, R_READ} resp_t;

   state_t state, state_nx;
   resp_t  resp_kind;

   logic [1:0]       rx_sync;
   logic             rx_busy, rx_valid;
   logic [CNT_W-1:0] rx_cnt, tx_cnt;
   logic [3:0]       rx_bit, tx_bits, resp_idx, resp_len_c;
   logic [7:0]       rx_sr, tx_hold, resp_byte_c;
   logic [9:0]       tx_sh;
   logic             tx_busy, tx_full;
   logic             in_tok, bad, hex_ok_c;
   logic [1:0]       tok_cnt, tok_cur_c, kw_len;
   logic [15:0]      kw;
   logic [5:0]       line_len;
   logic [31:0]      addr_f, data_f, rd_data, resp_text;
   logic [3:0]       hex_val_c;
   logic [TO_W-1:0]  to_cnt;
   logic             wr_ok_c, rd_ok_c, rx_char_c, cmd_go_c, cmd_err_c, push_c, bus_end_c, last_c;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // RX: start confirmed at mid-bit, data and one stop bit sampled at mid-bit
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_sync  <= 2'b11;
         rx_busy  <= 1'b0;
         rx_valid <= 1'b0;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sr    <= '0;
      end else begin
         rx_sync  <= {rx_sync[0], uart_rxd};
         rx_valid <= 1'b0;
         if (!rx_busy) begin
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_busy <= !rx_sync[1];
         end else if (rx_cnt == ((rx_bit == 4'd0) ? CNT_W'(HALF_CLKS - 1) : CNT_W'(BIT_CLKS - 1))) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
               rx_busy <= !rx_sync[1];
            end else if (rx_bit == 4'd9) begin
               rx_busy  <= 1'b0;
               rx_valid <= rx_sync[1];
            end else begin
               rx_sr <= {rx_sync[1], rx_sr[7:1]};
            end
         end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      hex_ok_c  = 1'b1;
      hex_val_c = rx_sr[3:0];
      tok_cur_c = in_tok ? (tok_cnt - 2'd1) : tok_cnt;
      if ((rx_sr >= 8'h61 && rx_sr <= 8'h66) || (rx_sr >= 8'h41 && rx_sr <= 8'h46))
         hex_val_c = rx_sr[3:0] + 4'd9;
      else if (!(rx_sr >= 8'h30 && rx_sr <= 8'h39))
         hex_ok_c = 1'b0;
      wr_ok_c = !bad && tok_cnt == 2'd3 && kw_len == 2'd2 && kw == 16'h776D;
      rd_ok_c = !bad && tok_cnt == 2'd2 && kw_len == 2'd2 && kw == 16'h726D;
   end

   // Line parser; state is cleared by every LF
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || (rx_char_c && rx_sr == CH_LF)) begin
         in_tok   <= 1'b0;
         tok_cnt  <= '0;
         kw       <= '0;
         kw_len   <= '0;
         addr_f   <= '0;
         data_f   <= '0;
         bad      <= 1'b0;
         line_len <= '0;
      end else if (rx_char_c && rx_sr != CH_CR) begin
         if (line_len != 6'd33) line_len <= line_len + 6'd1;
         if (line_len == 6'd32) bad <= 1'b1;
         if (rx_sr == CH_SP) begin
            in_tok <= 1'b0;
         end else begin
            in_tok <= 1'b1;
            if (!in_tok) begin
               if (tok_cnt == 2'd3) bad <= 1'b1;
               else tok_cnt <= tok_cnt + 2'd1;
            end
            case (tok_cur_c)
               2'd0: begin
                  kw <= {kw[7:0], rx_sr};
                  if (kw_len != 2'd3) kw_len <= kw_len + 2'd1;
               end
               2'd1: begin
                  addr_f <= {addr_f[27:0], hex_val_c};
                  if (!hex_ok_c) bad <= 1'b1;
               end
               2'd2: begin
                  data_f <= {data_f[27:0], hex_val_c};
                  if (!hex_ok_c) bad <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= S_BANNER;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_BANNER: if (push_c && last_c) state_nx = S_IDLE;
         S_IDLE:   if (cmd_go_c) state_nx = S_BUS;
                   else if (cmd_err_c) state_nx = S_RESP;
         S_BUS:    if (bus_end_c) state_nx = S_RESP;
         S_RESP:   if (push_c && last_c) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Per-state control strobes; received bytes are only consumed in IDLE
   always_comb begin
      rx_char_c = 1'b0;
      cmd_go_c  = 1'b0;
      cmd_err_c = 1'b0;
      push_c    = 1'b0;
      bus_end_c = 1'b0;
      case (state)
         S_IDLE: begin
            rx_char_c = rx_valid;
            if (rx_valid && rx_sr == CH_LF) begin
               cmd_go_c  = wr_ok_c || rd_ok_c;
               cmd_err_c = !(wr_ok_c || rd_ok_c) && (tok_cnt != 2'd0 || bad);
            end
         end
         S_BUS:    bus_end_c = wbm_ack_i || wbm_err_i || (to_cnt == TO_W'(WB_TIMEOUT - 1));
         S_BANNER, S_RESP: push_c = !tx_full;
         default: ;
      endcase
   end

   always_comb begin
      resp_text  = 32'h0;
      resp_len_c = 4'd3;
      case (resp_kind)
         R_BANNER: begin resp_text = 32'h5244_590A; resp_len_c = 4'd4; end
         R_OK:     resp_text = 32'h4F4B_0A00;
         R_ERR:    begin resp_text = 32'h4552_520A; resp_len_c = 4'd4; end
         R_TO:     resp_text = 32'h544F_0A00;
         R_READ:   resp_len_c = 4'd9;
         default: ;
      endcase
      last_c = (resp_idx == resp_len_c - 4'd1);
      if (resp_kind == R_READ)
         resp_byte_c = resp_idx[3] ? CH_LF : hex_ascii(rd_data[{~resp_idx[2:0], 2'b00} +: 4]);
      else
         resp_byte_c = resp_text[{~resp_idx[1:0], 3'b000} +: 8];
   end

   // Wishbone master and response selection
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         wbm_sel_o <= '0;
         to_cnt    <= '0;
         rd_data   <= '0;
         resp_kind <= R_BANNER;
         resp_idx  <= '0;
      end else begin
         if (cmd_go_c) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= 4'hF;
            wbm_we_o  <= wr_ok_c;
            wbm_adr_o <= addr_f;
            wbm_dat_o <= wr_ok_c ? data_f : 32'h0;
            to_cnt    <= '0;
         end
         if (cmd_err_c) begin
            resp_kind <= R_ERR;
            resp_idx  <= '0;
         end
         if (state == S_BUS) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (bus_end_c) begin
               wbm_cyc_o <= 1'b0;
               wbm_stb_o <= 1'b0;
               wbm_sel_o <= 4'h0;
               resp_idx  <= '0;
               if (wbm_ack_i) begin
                  resp_kind <= wbm_we_o ? R_OK : R_READ;
                  if (!wbm_we_o) rd_data <= wbm_dat_i;
               end else begin
                  resp_kind <= R_TO;
               end
            end
         end
         if (push_c) resp_idx <= resp_idx + 4'd1;
      end
   end

   // TX: holding buffer feeds an 11-bit frame shifter (start, 8 data, 2 stop)
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         uart_txd <= 1'b1;
         tx_busy  <= 1'b0;
         tx_full  <= 1'b0;
         tx_hold  <= '0;
         tx_sh    <= '0;
         tx_cnt   <= '0;
         tx_bits  <= '0;
      end else begin
         if (push_c) begin
            tx_hold <= resp_byte_c;
            tx_full <= 1'b1;
         end
         if (!tx_busy) begin
            if (tx_full) begin
               tx_busy  <= 1'b1;
               tx_full  <= 1'b0;
               uart_txd <= 1'b0;
               tx_sh    <= {2'b11, tx_hold};
               tx_cnt   <= '0;
               tx_bits  <= '0;
            end
         end else if (tx_cnt == CNT_W'(BIT_CLKS - 1)) begin
            tx_cnt <= '0;
            if (tx_bits == 4'd10) begin
               tx_busy <= 1'b0;
            end else begin
               uart_txd <= tx_sh[0];
               tx_sh    <= {1'b1, tx_sh[9:1]};
               tx_bits  <= tx_bits + 4'd1;
            end
         end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_caravel_uart_wb_master.sv
// Directed bench for the UART-to-Wishbone bridge: UART command driver, TX decoder,
// simple Wishbone slave, and hand-computed expected replies and bus fields.
module tb_caravel_uart_wb_master;
   localparam int BIT = 16;   // BAUD_DIV = 0

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rxd = 1'b1;
   logic        txd;
   logic        cyc, stb, we;
   logic [31:0] adr, dat_o;
   logic [3:0]  sel;
   logic [31:0] dat_i = 32'h0;
   logic        ack = 1'b0;
   logic        err = 1'b0;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  rx_q[$];
   logic [7:0]  mon_b;
   int          mode = 0;      // 0: ack after one cycle, 1: never ack
   logic [31:0] rd_val = 32'h0;
   int          n_ack = 0;
   int          cyc_hi = 0;
   logic [31:0] cap_adr = 32'h0, cap_dat = 32'h0;
   logic        cap_we = 1'b0;
   logic [3:0]  cap_sel = 4'h0;
   int          base_ack, base_cyc, low_cnt, waited;

   caravel_uart_wb_master #(.BAUD_DIV(0), .WB_TIMEOUT(1023)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .uart_rxd (rxd),
      .uart_txd (txd),
      .wbm_cyc_o(cyc),
      .wbm_stb_o(stb),
      .wbm_we_o (we),
      .wbm_adr_o(adr),
      .wbm_dat_o(dat_o),
      .wbm_sel_o(sel),
      .wbm_dat_i(dat_i),
      .wbm_ack_i(ack),
      .wbm_err_i(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Slave: samples the bus away from the DUT's clock edge
   always @(negedge clk) begin
      if (cyc && stb) begin
         cyc_hi++;
         cap_adr = adr;
         cap_dat = dat_o;
         cap_we  = we;
         cap_sel = sel;
         if (mode == 0 && !ack) begin
            ack   = 1'b1;
            dat_i = rd_val;
            n_ack++;
         end
      end else begin
         ack   = 1'b0;
         dat_i = 32'h0;
      end
   end

   // TX decoder: 8 data bits LSB first, first stop bit must be high
   initial begin : tx_mon
      forever begin
         @(negedge clk);
         if (txd === 1'b0 && rst === 1'b0) begin
            repeat (BIT / 2) @(negedge clk);
            if (txd === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (BIT) @(negedge clk);
                  mon_b[i] = txd;
               end
               repeat (BIT) @(negedge clk);
               if (txd === 1'b1) rx_q.push_back(mon_b);
            end
         end
      end
   end

   task automatic uart_send(input logic [7:0] b, input bit stop_ok);
      @(negedge clk);
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      if (stop_ok) begin
         rxd = 1'b1;
         repeat (BIT) @(negedge clk);
      end else begin
         rxd = 1'b0;
         repeat (BIT * 3 / 4) @(negedge clk);
         rxd = 1'b1;
         repeat (BIT * 2) @(negedge clk);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) uart_send(s[i], 1'b1);
   endtask

   task automatic expect_str(input string tag, input string s);
      for (int i = 0; i < s.len(); i++) begin
         waited = 0;
         while (rx_q.size() == 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
         end
         if (rx_q.size() == 0) begin
            chk({tag, "_rx"}, 32'(rx_q.size()), 32'd1);
            return;
         end
         chk(tag, 32'(rx_q.pop_front()), 32'(s[i]));
      end
   endtask

   initial begin
      repeat (5) @(negedge clk);
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_cyc", 32'(cyc), 32'd0);
      chk("rst_stb", 32'(stb), 32'd0);
      chk("rst_we",  32'(we),  32'd0);
      chk("rst_adr", adr, 32'h0);
      chk("rst_dat", dat_o, 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      rst = 1'b0;

      // 'R' = 0x52: start bit plus d0=0 keep the line low for two bit times
      waited = 0;
      while (txd !== 1'b0 && waited < 200) begin @(negedge clk); waited++; end
      low_cnt = 0;
      while (txd === 1'b0 && low_cnt < 200) begin @(negedge clk); low_cnt++; end
      chk("banner_low_width", 32'(low_cnt), 32'(2 * BIT));
      expect_str("banner", "RDY\n");

      base_ack = n_ack;
      send_str("wm 30020000 11223344\n");
      expect_str("wm_reply", "OK\n");
      chk("wm_count", 32'(n_ack - base_ack), 32'd1);
      chk("wm_adr", cap_adr, 32'h3002_0000);
      chk("wm_dat", cap_dat, 32'h1122_3344);
      chk("wm_we",  32'(cap_we), 32'd1);
      chk("wm_sel", 32'(cap_sel), 32'hF);

      rd_val = 32'h4433_2211;
      send_str("rm 30000000\n");
      expect_str("rm0_reply", "44332211\n");
      chk("rm0_adr", cap_adr, 32'h3000_0000);
      chk("rm0_we",  32'(cap_we), 32'd0);

      rd_val = 32'hDDCC_BBAA;
      send_str("rm 30000004\n");
      expect_str("rm4_reply", "DDCCBBAA\n");
      chk("rm4_adr", cap_adr, 32'h3000_0004);

      send_str("wm 3000000c aBcDeF01\n");
      expect_str("wm_lc_reply", "OK\n");
      chk("wm_lc_adr", cap_adr, 32'h3000_000C);
      chk("wm_lc_dat", cap_dat, 32'hABCD_EF01);

      rd_val = 32'h0000_BEEF;
      send_str("rm 9876543210\n");
      expect_str("rm_long_reply", "0000BEEF\n");
      chk("rm_long_adr", cap_adr, 32'h7654_3210);

      base_cyc = cyc_hi;
      send_str("xx 1\n");
      expect_str("bad_kw", "ERR\n");
      send_str("wm 12\n");
      expect_str("missing_field", "ERR\n");
      send_str("rm 0000000000000000000000000000001\n");
      expect_str("line_too_long", "ERR\n");
      chk("err_no_bus", 32'(cyc_hi - base_cyc), 32'd0);

      send_str("\r\n");
      repeat (30 * BIT) @(negedge clk);
      chk("empty_line", 32'(rx_q.size()), 32'd0);

      // Corrupted byte in the middle of a valid line must be ignored
      rd_val = 32'h1234_5678;
      send_str("rm 3000");
      uart_send(8'h5A, 1'b0);
      send_str("0000\n");
      expect_str("frame_reply", "12345678\n");
      chk("frame_adr", cap_adr, 32'h3000_0000);

      mode = 1;
      base_cyc = cyc_hi;
      send_str("rm 0\n");
      expect_str("to_reply", "TO\n");
      chk("to_cycles", 32'(cyc_hi - base_cyc), 32'd1023);
      chk("to_adr", cap_adr, 32'h0);

      send_str("rm 0\n");
      chk("bus_active", 32'(cyc), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_bus_cyc", 32'(cyc), 32'd0);
      chk("rst_bus_stb", 32'(stb), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      mode = 0;
      expect_str("banner2", "RDY\n");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
